uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from any producer (command logic, bridge, CPU port) in single-cycle writes and stores them in a circular FIFO. It drains the FIFO one byte per serial frame, driving the transmitter's data-valid/byte inputs and pacing on its Active/Done outputs, so producers never have to track serial timing.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and launch sequencer in front of a UART transmitter. Producers
// push bytes with single-cycle writes into a circular FIFO; the sequencer
// pops one byte per serial frame and hands it to the transmitter with a
// one-cycle launch pulse, pacing itself on the transmitter's Active/Done.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, i_Wr_Byte captured when high
//   i_Wr_Byte    byte to enqueue
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds 0 bytes
//   o_Count      occupancy, 0..DEPTH
//   o_Overflow   sticky, set when a write is dropped
//   o_Tx_DV      one-cycle launch pulse to the transmitter
//   o_Tx_Byte    byte presented with o_Tx_DV, holds last launched value
//   i_Tx_Active  transmitter busy with a frame
//   i_Tx_Done    transmitter end-of-frame pulse
//
// Sequencer states
//   state       | meaning
//   S_IDLE      | waiting for data and an idle transmitter; pops on exit
//   S_LAUNCH    | o_Tx_DV high for this single cycle
//   S_WAIT_ACT  | waiting for the transmitter to report Active (or Done)
//   S_WAIT_DONE | frame in flight, waiting for Done
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACT,
        S_WAIT_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_d;

    logic              pop;
    logic              push;
    logic              drop;

    // A full FIFO still accepts a write when the same edge frees a slot.
    // Pop is decided from registered o_Empty, so a byte written into an
    // empty FIFO is never popped on the edge it arrives.
    assign push = i_Wr_DV & (~o_Full | pop);
    assign drop = i_Wr_DV & o_Full & ~pop;

    // ----------------------------------------------------------------------
    // Sequencer next-state
    // ----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Active guard also covers a frame still running in the
                // transmitter after this block was reset mid-frame.
                if (!o_Empty && !i_Tx_Active) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end else if (i_Tx_Active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------------------
    // Occupancy
    // ----------------------------------------------------------------------
    always_comb begin
        count_d = o_Count;
        if (push && !pop) begin
            count_d = o_Count + CNT_ONE;
        end else if (pop && !push) begin
            count_d = o_Count - CNT_ONE;
        end
    end

    // ----------------------------------------------------------------------
    // Pointers, flags and transmitter outputs
    // ----------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                o_Tx_Byte <= mem[rd_ptr];
            end
            if (drop) begin
                o_Overflow <= 1'b1;
            end
            // Flags derive from the same next count so they never disagree.
            o_Count <= count_d;
            o_Full  <= (count_d == FULL_CNT);
            o_Empty <= (count_d == '0);
            o_Tx_DV <= (state_d == S_LAUNCH);
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && push) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a small transmitter model answers launches,
// a monitor checks each launched byte against a queue of expected bytes.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_dv;
    logic [7:0] wr_byte;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic       tx_dv;
    logic [7:0] tx_byte;

    logic       tx_active   = 1'b0;
    logic       tx_done     = 1'b0;
    logic       hold_active = 1'b0;
    logic [5:0] tx_cnt      = 6'd0;
    logic       act_in;

    assign act_in = tx_active | hold_active;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (act_in),
        .i_Tx_Done   (tx_done)
    );

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_pulse = 0;
    bit         launched = 1'b0;
    logic [7:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Transmitter model: 10-bit frame at 4 clocks per bit (40 clocks);
    // Active drops together with the one-cycle Done pulse. Not reset by rst,
    // so a frame keeps running across a reset of the FIFO.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            if (tx_dv) begin
                tx_active <= 1'b1;
                tx_cnt    <= 6'd39;
            end
        end else if (tx_cnt == 6'd0) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
        end else begin
            tx_cnt <= tx_cnt - 6'd1;
        end
    end

    // Monitor: every launch pulse consumes one expected byte.
    always @(negedge clk) begin
        if (tx_dv) begin
            n_pulse++;
            check("launch_without_done", {31'd0, launched}, 32'd0);
            launched = 1'b1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_launch: got byte %0h, expected no launch", tx_byte);
            end else begin
                check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
            end
        end
        if (tx_done) launched = 1'b0;
    end

    // Caller is at a negedge; drives one write and returns at the next negedge.
    task automatic put(input logic [7:0] b, input bit acc);
        wr_dv   = 1'b1;
        wr_byte = b;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && empty && !tx_active && !tx_dv) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    int         p0;
    int         peak;
    int         early;

    initial begin
        rst     = 1'b1;
        wr_dv   = 1'b0;
        wr_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        rst = 1'b0;

        // Single byte: count after write edge, launch one edge later.
        put(8'hA5, 1'b1);
        wr_dv = 1'b0;
        check("single_count1", count, 1);
        check("single_dv_early", tx_dv, 0);
        @(negedge clk);
        check("single_dv_launch", tx_dv, 1);
        check("single_count0", count, 0);
        @(negedge clk);
        check("single_dv_one_cycle", tx_dv, 0);
        wait_drain();
        check("single_empty_after", empty, 1);

        // Burst 01..05 on consecutive cycles.
        p0   = n_pulse;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            put(8'(i), 1'b1);
            if (int'(count) > peak) peak = int'(count);
        end
        wr_dv = 1'b0;
        wait_drain();
        check("burst_peak", peak, 4);
        check("burst_pulses", n_pulse - p0, 5);

        // Fill to 16 with transmitter held busy, 17th write dropped.
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) put(8'h10 + 8'(i), 1'b1);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_ovf_clear", ovf, 0);
        put(8'hFF, 1'b0);
        wr_dv = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        p0 = n_pulse;
        hold_active = 1'b0;
        wait_drain();
        check("ovf_drain_pulses", n_pulse - p0, 16);
        check("ovf_sticky", ovf, 1);

        // Write on the same edge as a pop from a full FIFO.
        do_reset();
        check("reset_clears_ovf", ovf, 0);
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) put(8'h40 + 8'(i), 1'b1);
        p0 = n_pulse;
        hold_active = 1'b0;
        put(8'hEE, 1'b1);
        wr_dv = 1'b0;
        check("pushpop_count", count, 16);
        check("pushpop_full", full, 1);
        check("pushpop_ovf", ovf, 0);
        wait_drain();
        check("pushpop_pulses", n_pulse - p0, 17);

        // Pointer wrap: 40 bytes, writes paced on o_Full.
        p0 = n_pulse;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 200 && full; k++) @(negedge clk);
            put(8'h80 + 8'(i), 1'b1);
            wr_dv = 1'b0;
        end
        wait_drain();
        check("wrap_pulses", n_pulse - p0, 40);
        check("wrap_ovf", ovf, 0);

        // Reset during data bit 3 with 3 bytes still queued.
        for (int i = 0; i < 4; i++) put(8'h31 + 8'(i), 1'b1);
        wr_dv = 1'b0;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if (tx_active && tx_cnt == 6'd21) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("midframe_reached", {31'd0, hit}, 32'd1);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_ovf", ovf, 0);
        p0 = n_pulse;
        put(8'h5A, 1'b1);
        wr_dv = 1'b0;
        early = 0;
        for (int i = 0; i < 200 && tx_active; i++) begin
            if (tx_dv) early++;
            @(negedge clk);
        end
        check("midrst_no_early_launch", early, 0);
        wait_drain();
        check("midrst_pulses", n_pulse - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
